// File: rtl/vram_arbiter_pkg.sv
// Shared framebuffer geometry and arbiter state encoding for the VGA/CPU
// framebuffer arbiter and its helpers.
package vram_arbiter_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_SIZE   = FB_W * FB_H;
  localparam int PIX_W     = 12;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
  } arb_state_t;
endpackage

// File: rtl/vram_addr_gen.sv
// Display row/col to linear framebuffer address, with 2x2 pixel doubling.
// Purely combinational so the RAM read is issued in the same cycle as row/col.
module vram_addr_gen #(
  parameter int H_RES  = 320,
  parameter int ADDR_W = 17
) (
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] c;
  logic [ADDR_W-1:0] base;

  assign r = ADDR_W'(row[8:1]);
  assign c = ADDR_W'(col[9:1]);

  // 320 = 256 + 64, so the default width needs no multiplier.
  generate
    if (H_RES == 320) begin : g_shift
      assign base = (r << 8) + (r << 6);
    end else begin : g_mul
      assign base = ADDR_W'(r * ADDR_W'(H_RES));
    end
  endgenerate

  assign addr = base + c;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA fetch owns the RAM in the active
// window, CPU req/ack accesses are served only during blanking.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int H_RES  = FB_W,
  parameter int V_RES  = FB_H,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_rdn,
  output logic [DATA_W-1:0] vga_din,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  arb_state_t        state;
  logic [ADDR_W-1:0] vga_addr;
  logic              in_range;
  logic              cpu_go;

  vram_addr_gen #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .row  (vga_row),
    .col  (vga_col),
    .addr (vga_addr)
  );

  assign vga_din  = ram_rdata;
  assign in_range = (cpu_addr < ADDR_W'(H_RES * V_RES));
  assign cpu_go   = vga_rdn && (state == IDLE) && cpu_req;

  // The write strobe is also masked by rst so no write can leak out while
  // the arbiter is being held in reset with a request still pending.
  always_comb begin
    ram_addr  = vga_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (cpu_go && in_range) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && !rst;
      ram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_go) begin
            if (!in_range) begin
              state     <= HOLD;
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else if (cpu_we) begin
              state   <= HOLD;
              cpu_ack <= 1'b1;
              cpu_err <= 1'b0;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        // The read was issued last cycle, so capture regardless of vga_rdn.
        RD_WAIT: begin
          state     <= HOLD;
          cpu_ack   <= 1'b1;
          cpu_rdata <= ram_rdata;
          cpu_err   <= 1'b0;
        end
        HOLD: begin
          if (!cpu_req) begin
            state   <= IDLE;
            cpu_ack <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM model.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  vga_row;
  logic [9:0]  vga_col;
  logic        vga_rdn;
  logic [11:0] vga_din;
  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        cpu_err;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  logic [11:0] mem [0:131071];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .vga_row   (vga_row),
    .vga_col   (vga_col),
    .vga_rdn   (vga_rdn),
    .vga_din   (vga_din),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [11:0] pix(int a);
    return 12'((a * 7) ^ 12'h5A5);
  endfunction

  function automatic logic [16:0] vexp(int r, int c);
    return 17'((r / 2) * 320 + (c / 2));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = pix(i);
    rst = 1'b1; vga_row = '0; vga_col = '0; vga_rdn = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    rst = 1'b0;

    // VGA fetch addressing
    @(negedge clk);
    vga_rdn = 1'b0; vga_row = 9'd3; vga_col = 10'd5;
    #1;
    chk("vga_addr_3_5", 32'(ram_addr), 32'd322);
    chk("vga_we_0", 32'(ram_we), 32'd0);
    @(negedge clk);
    chk("vga_din_322", 32'(vga_din), 32'(pix(322)));
    vga_row = 9'd479; vga_col = 10'd639;
    #1;
    chk("vga_addr_max", 32'(ram_addr), 32'd76799);
    @(negedge clk);
    chk("vga_din_max", 32'(vga_din), 32'(pix(76799)));

    // CPU write in blanking
    vga_rdn = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 17'd100; cpu_wdata = 12'hF0A;
    #1;
    chk("wr_addr", 32'(ram_addr), 32'd100);
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_wdata", 32'(ram_wdata), 32'hF0A);
    chk("wr_ack_pre", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    chk("wr_err", 32'(cpu_err), 32'd0);
    chk("wr_we_hold", 32'(ram_we), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wr_ack_held", 32'(cpu_ack), 32'd1);
    end
    cpu_req = 1'b0;
    #1;
    chk("wr_ack_lag", 32'(cpu_ack), 32'd1);
    @(negedge clk);
    chk("wr_ack_drop", 32'(cpu_ack), 32'd0);
    chk("wr_mem", 32'(mem[100]), 32'hF0A);

    // Read deferred through 50 active-window cycles
    vga_rdn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd76799;
    for (int i = 0; i < 50; i++) begin
      vga_row = 9'((i * 37) % 480);
      vga_col = 10'((i * 53) % 640);
      #1;
      chk("def_we", 32'(ram_we), 32'd0);
      chk("def_addr", 32'(ram_addr), 32'(vexp((i * 37) % 480, (i * 53) % 640)));
      chk("def_ack", 32'(cpu_ack), 32'd0);
      @(negedge clk);
    end
    vga_rdn = 1'b1;
    #1;
    chk("rd_addr", 32'(ram_addr), 32'd76799);
    chk("rd_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    chk("rd_ack_wait", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'(pix(76799)));
    chk("rd_err", 32'(cpu_err), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_drop", 32'(cpu_ack), 32'd0);

    // Out-of-range write
    vga_row = 9'd20; vga_col = 10'd40;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 12'h123;
    #1;
    chk("oor_we", 32'(ram_we), 32'd0);
    chk("oor_addr", 32'(ram_addr), 32'(vexp(20, 40)));
    @(negedge clk);
    chk("oor_ack", 32'(cpu_ack), 32'd1);
    chk("oor_err", 32'(cpu_err), 32'd1);
    chk("oor_rdata", 32'(cpu_rdata), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("oor_ack_drop", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd7;
    @(negedge clk);
    @(negedge clk);
    chk("clr_ack", 32'(cpu_ack), 32'd1);
    chk("clr_err", 32'(cpu_err), 32'd0);
    chk("clr_rdata", 32'(cpu_rdata), 32'(pix(7)));
    cpu_req = 1'b0;
    @(negedge clk);

    // Read accepted on last blanking cycle, active window starts in RD_WAIT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd200;
    #1;
    chk("edge_addr", 32'(ram_addr), 32'd200);
    @(negedge clk);
    vga_rdn = 1'b0; vga_row = 9'd10; vga_col = 10'd20;
    #1;
    chk("edge_vaddr", 32'(ram_addr), 32'd1610);
    chk("edge_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    chk("edge_ack", 32'(cpu_ack), 32'd1);
    chk("edge_rdata", 32'(cpu_rdata), 32'(pix(200)));
    chk("edge_vdin", 32'(vga_din), 32'(pix(1610)));
    cpu_req = 1'b0; vga_rdn = 1'b1;
    @(negedge clk);
    chk("edge_ack_drop", 32'(cpu_ack), 32'd0);

    // Asynchronous reset while holding a write ack
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd400; cpu_wdata = 12'h321;
    @(negedge clk);
    chk("ar_ack_pre", 32'(cpu_ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ack", 32'(cpu_ack), 32'd0);
    chk("ar_rdata", 32'(cpu_rdata), 32'd0);
    chk("ar_err", 32'(cpu_err), 32'd0);
    chk("ar_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_idle_we", 32'(ram_we), 32'd1);
    chk("ar_idle_addr", 32'(ram_addr), 32'd400);
    @(negedge clk);
    chk("ar_ack_new", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ar_ack_drop", 32'(cpu_ack), 32'd0);
    chk("ar_mem", 32'(mem[400]), 32'h321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
